codec_dsp_port: RTL and testbench
=================================

# codec_dsp_port

Bidirectional serial audio port between the FPGA fabric and the audio codec once the codec SPI configurator has finished. The codec is bus master (MS=1, DSP format, LRP=1 i.e. mode B, BCLKINV=0). The block recovers BCLK/LRC edges in the system clock domain, deserialises ADCDAT into parallel left/right samples, and serialises parallel samples onto DACDAT. It sits downstream of the configurator, whose `done` drives `enable`.

## Interface

- `BITSIZE`, 24: sample width per channel; legal values 16 and 24, matching codec IWL.
- `clk` in 1: system clock; frequency ≥ 8× BCLK.
- `resetn` in 1: synchronous, active-low reset.
- `enable` in 1: from configurator `done`; low holds the port idle.
- `bclk` in 1: codec bit clock, asynchronous.
- `lrclk` in 1: codec DACLRC/ADCLRC, one-BCLK-wide frame pulse, asynchronous.
- `adcdat` in 1: codec ADC serial data; changes on BCLK falling edge.
- `dacdat` out 1: codec DAC serial data; codec samples it on BCLK rising edge.
- `left_out` out BITSIZE: last received left sample.
- `right_out` out BITSIZE: last received right sample.
- `out_valid` out 1: one-clk pulse; `left_out`/`right_out` updated this cycle.
- `left_in` in BITSIZE: next left sample to transmit.
- `right_in` in BITSIZE: next right sample to transmit.
- `in_ready` out 1: one-clk pulse; `left_in`/`right_in` captured this cycle.
- `frame_err` out 1: one-clk pulse; frame pulse arrived mid-frame.

## Operation

- `bclk`, `lrclk`, `adcdat` each pass through a 2-FF synchronizer plus one history FF. Rise/fall events are derived from synchronized `bclk`. `lrclk`/`adcdat` values are taken from the same pipeline stage as the `bclk` edge.
- The state is a 6-bit bit counter `bitcnt` with range 0..2·BITSIZE; value 2·BITSIZE means IDLE.
- Rise event:
  - If `lrclk` is 1: frame start. Capture `adcdat` as left MSB and set `bitcnt` = 1.
  - If `lrclk` is 1 and `bitcnt` is neither IDLE nor 0: also pulse `frame_err`. The frame restarts and the partial RX data is discarded.
  - Else, if `bitcnt` < 2·BITSIZE: shift `adcdat` into the RX shift register and increment `bitcnt`.
  - When `bitcnt` reaches 2·BITSIZE: `left_out` = rx[2B-1:B], `right_out` = rx[B-1:0], and pulse `out_valid` on the next cycle.
- Fall event:
  - If 1 ≤ `bitcnt` < 2·BITSIZE: shift the TX register left by one bit.
  - If `bitcnt` = 2·BITSIZE and a load is pending: load TX = {`left_in`, `right_in`}, pulse `in_ready` in the same cycle, and clear the pending flag.
  - The pending flag is set at each frame start.
- `dacdat` = TX[2B-1] at all times. The next left MSB is therefore already on the line before the LRC pulse; this is required for mode B.
- Bits 2·BITSIZE..63 of the 64-BCLK frame are ignored on RX. TX holds the preloaded MSB during those bits.
- `enable` low:
  - `bitcnt` = IDLE, TX register = 0, no pulses.
  - RX/TX resume only at the first full frame start after `enable` rises; a partial frame is never emitted.

## Timing

- Reset (`resetn` = 0 at a `clk` edge): `dacdat` 0, `left_out` 0, `right_out` 0, `out_valid` 0, `in_ready` 0, `frame_err` 0; TX and RX registers 0; `bitcnt` = IDLE; synchronizers cleared. Reset mid-frame abandons the frame with no pulse.
- Pin-to-event latency: 3 clk cycles from an external BCLK edge to the internal event.
- RX latency: `out_valid` is asserted 4 clk cycles after the BCLK rising edge that carries the right-channel LSB.
- TX load happens on the first BCLK falling edge after the right LSB is consumed. `left_in`/`right_in` must be stable in the `in_ready` cycle; no backpressure is applied.
- Frame-start `frame_err` and the new frame start occur in the same cycle. `out_valid` and `in_ready` can never coincide, because they fire on different BCLK edges.
- `bitcnt` saturates at IDLE and never wraps.

## Test plan

- **Reset values:** hold `resetn` low 4 cycles with `enable` = 1 and toggling BCLK → all outputs 0 and `dacdat` stays 0 throughout.
- **RX frame:** BITSIZE=24, BCLK = clk/8, send frame left 0xABCDEF, right 0x123456 → one `out_valid`, `left_out` = 0xABCDEF, `right_out` = 0x123456, `frame_err` 0.
- **TX frame:** present `left_in` 0x800001, `right_in` 0x7FFFFF at `in_ready` → next frame DACDAT bits sampled at BCLK rising edges read back as 0x800001 then 0x7FFFFF, MSB valid at the LRC-high rising edge.
- **Early frame pulse:** LRC pulse after 30 bits → one `frame_err` pulse, no `out_valid` for the truncated frame, and the next full frame decoded correctly.
- **Enable mid-frame:** raise `enable` 10 BCLKs into a frame → no `out_valid` for that frame; the first `out_valid` comes after the next complete frame.
- **Streaming, BITSIZE=16:** 100 back-to-back frames with incrementing data → exactly 100 `out_valid` and 100 `in_ready` pulses, data matches in order, `frame_err` never asserts.

Source files
------------

// File: rtl/codec_dsp_port.sv
// codec_dsp_port: serial audio port for a codec running as bus master in
// DSP mode B. BCLK/LRC/ADCDAT are resynchronised into clk, a bit counter
// tracks the frame, ADCDAT is deserialised into left/right samples and a
// parallel left/right pair is serialised onto DACDAT.
module codec_dsp_port #(
    parameter int BITSIZE = 24
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               bclk,
    input  logic               lrclk,
    input  logic               adcdat,
    output logic               dacdat,
    output logic [BITSIZE-1:0] left_out,
    output logic [BITSIZE-1:0] right_out,
    output logic               out_valid,
    input  logic [BITSIZE-1:0] left_in,
    input  logic [BITSIZE-1:0] right_in,
    output logic               in_ready,
    output logic               frame_err
);

    localparam int         NB   = 2 * BITSIZE;
    // Bit counter value meaning "no frame in progress"; saturates here.
    localparam logic [5:0] IDLE = 6'(NB);

    // Synchronizer stages: bit 0 = bclk, bit 1 = lrclk, bit 2 = adcdat.
    logic [2:0] pin_s1_q, pin_s1_d;
    logic [2:0] pin_s2_q, pin_s2_d;
    logic       bclk_h_q, bclk_h_d;

    logic          rise_evt;
    logic          fall_evt;
    logic          lrc_s;
    logic          adc_s;

    logic [5:0]    bitcnt_q, bitcnt_d;
    logic [NB-1:0] rx_q, rx_d;
    logic [NB-1:0] tx_q, tx_d;
    logic          pend_q, pend_d;
    logic          rx_full_q, rx_full_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [BITSIZE-1:0] left_out_q, left_out_d;
    logic [BITSIZE-1:0] right_out_q, right_out_d;
    logic          in_ready_c;

    // Next-state of the synchronizer chain and the bclk history flop.
    always_comb begin
        pin_s1_d = {adcdat, lrclk, bclk};
        pin_s2_d = pin_s1_q;
        bclk_h_d = pin_s2_q[0];
    end

    // Synchronizer registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pin_s1_q <= '0;
            pin_s2_q <= '0;
            bclk_h_q <= 1'b0;
        end else begin
            pin_s1_q <= pin_s1_d;
            pin_s2_q <= pin_s2_d;
            bclk_h_q <= bclk_h_d;
        end
    end

    // lrclk/adcdat are taken from the same stage that completes the bclk edge.
    assign rise_evt = pin_s2_q[0] & ~bclk_h_q;
    assign fall_evt = ~pin_s2_q[0] & bclk_h_q;
    assign lrc_s    = pin_s2_q[1];
    assign adc_s    = pin_s2_q[2];

    // Frame tracking, RX deserialiser, TX serialiser and output pulses.
    always_comb begin
        bitcnt_d    = bitcnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        pend_d      = pend_q;
        rx_full_d   = 1'b0;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        left_out_d  = left_out_q;
        right_out_d = right_out_q;
        in_ready_c  = 1'b0;

        if (!enable) begin
            bitcnt_d = IDLE;
            tx_d     = '0;
            pend_d   = 1'b0;
        end else begin
            // Publish a completed frame one cycle after its last bit lands.
            if (rx_full_q) begin
                out_valid_d = 1'b1;
                left_out_d  = rx_q[NB-1:BITSIZE];
                right_out_d = rx_q[BITSIZE-1:0];
            end

            if (rise_evt) begin
                if (lrc_s) begin
                    // Frame start: any partial frame is dropped.
                    rx_d        = {{(NB-1){1'b0}}, adc_s};
                    bitcnt_d    = 6'd1;
                    pend_d      = 1'b1;
                    frame_err_d = (bitcnt_q != IDLE) && (bitcnt_q != 6'd0);
                end else if (bitcnt_q < IDLE) begin
                    rx_d      = {rx_q[NB-2:0], adc_s};
                    bitcnt_d  = bitcnt_q + 6'd1;
                    rx_full_d = (bitcnt_q == IDLE - 6'd1);
                end
            end

            if (fall_evt) begin
                if ((bitcnt_q >= 6'd1) && (bitcnt_q < IDLE)) begin
                    tx_d = {tx_q[NB-2:0], 1'b0};
                end else if ((bitcnt_q == IDLE) && pend_q) begin
                    // Preload so the next left MSB is on the line before LRC.
                    tx_d       = {left_in, right_in};
                    in_ready_c = 1'b1;
                    pend_d     = 1'b0;
                end
            end
        end
    end

    // Core state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bitcnt_q    <= IDLE;
            rx_q        <= '0;
            tx_q        <= '0;
            pend_q      <= 1'b0;
            rx_full_q   <= 1'b0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            left_out_q  <= '0;
            right_out_q <= '0;
        end else begin
            bitcnt_q    <= bitcnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            pend_q      <= pend_d;
            rx_full_q   <= rx_full_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            left_out_q  <= left_out_d;
            right_out_q <= right_out_d;
        end
    end

    assign dacdat    = tx_q[NB-1];
    assign left_out  = left_out_q;
    assign right_out = right_out_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign in_ready  = in_ready_c;

endmodule

// File: tb/tb_codec_dsp_port.sv
// Testbench for codec_dsp_port: one 24-bit and one 16-bit instance share the
// serial lines; each has its own enable. RX/TX expectations go through queues.
module tb_codec_dsp_port;

    logic clk;
    logic resetn;
    logic en24, en16;
    logic bclk, lrclk, adcdat;

    logic        dac24, ov24, ir24, fe24;
    logic [23:0] lo24, ro24, lin24, rin24;
    logic        dac16, ov16, ir16, fe16;
    logic [15:0] lo16, ro16, lin16, rin16;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lsb_cyc = 0;
    int ov24_cnt = 0, ir24_cnt = 0, fe24_cnt = 0;
    int ov16_cnt = 0, ir16_cnt = 0, fe16_cnt = 0;
    bit upd24 = 0, upd16 = 0;

    logic [47:0] rxq24[$];
    logic [47:0] txq24[$];
    logic [31:0] rxq16[$];
    logic [31:0] txq16[$];

    codec_dsp_port #(.BITSIZE(24)) dut24 (
        .clk(clk), .resetn(resetn), .enable(en24),
        .bclk(bclk), .lrclk(lrclk), .adcdat(adcdat), .dacdat(dac24),
        .left_out(lo24), .right_out(ro24), .out_valid(ov24),
        .left_in(lin24), .right_in(rin24), .in_ready(ir24), .frame_err(fe24)
    );

    codec_dsp_port #(.BITSIZE(16)) dut16 (
        .clk(clk), .resetn(resetn), .enable(en16),
        .bclk(bclk), .lrclk(lrclk), .adcdat(adcdat), .dacdat(dac16),
        .left_out(lo16), .right_out(ro16), .out_valid(ov16),
        .left_in(lin16), .right_in(rin16), .in_ready(ir16), .frame_err(fe16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 24-bit instance: RX scoreboard, TX load capture, pulse counting.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (ov24 === 1'b1) begin
                ov24_cnt++;
                check("rx24_latency", 64'(cyc - lsb_cyc), 64'd4);
                check("rx24_expected", {63'b0, rxq24.size() > 0}, 64'd1);
                if (rxq24.size() > 0) check("rx24_data", {lo24, ro24}, rxq24.pop_front());
                $display("RX24 out_valid left=%h right=%h", lo24, ro24);
            end
            if (ov24 === 1'b1 || ir24 === 1'b1) check("ov_ir_overlap24", {63'b0, ov24 & ir24}, 64'd0);
            if (fe24 === 1'b1) begin
                fe24_cnt++;
                $display("RX24 frame_err");
            end
            if (ir24 === 1'b1) begin
                ir24_cnt++;
                txq24.push_back({lin24, rin24});
                upd24 = 1;
                $display("TX24 load left=%h right=%h", lin24, rin24);
            end else if (upd24) begin
                upd24 = 0;
                lin24 = lin24 + 24'h111111;
                rin24 = rin24 - 24'h010203;
            end
        end
    end

    // 16-bit instance: same scoreboard duties.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (ov16 === 1'b1) begin
                ov16_cnt++;
                check("rx16_latency", 64'(cyc - lsb_cyc), 64'd4);
                check("rx16_expected", {63'b0, rxq16.size() > 0}, 64'd1);
                if (rxq16.size() > 0) check("rx16_data", {lo16, ro16}, rxq16.pop_front());
                $display("RX16 out_valid left=%h right=%h", lo16, ro16);
            end
            if (ov16 === 1'b1 || ir16 === 1'b1) check("ov_ir_overlap16", {63'b0, ov16 & ir16}, 64'd0);
            if (fe16 === 1'b1) begin
                fe16_cnt++;
                $display("RX16 frame_err");
            end
            if (ir16 === 1'b1) begin
                ir16_cnt++;
                txq16.push_back({lin16, rin16});
                upd16 = 1;
                $display("TX16 load left=%h right=%h", lin16, rin16);
            end else if (upd16) begin
                upd16 = 0;
                lin16 = lin16 + 16'd1;
                rin16 = rin16 + 16'h0101;
            end
        end
    end

    // One frame of nbits BCLK periods (8 clk each). Data changes on the BCLK
    // falling edge; DACDAT is sampled at each BCLK rising edge.
    task automatic send_frame(input int bsz, input logic [47:0] fd, input int nbits,
                              input int raise_at, input bit push_rx, input bit chk_tx);
        int nb;
        logic [47:0] got;
        logic [47:0] exp;
        bit have;
        nb = 2 * bsz;
        got = '0;
        exp = '0;
        have = 0;
        if (bsz == 24) begin
            if (txq24.size() > 0) begin exp = txq24.pop_front(); have = 1; end
            if (push_rx) rxq24.push_back(fd);
        end else begin
            if (txq16.size() > 0) begin exp = {16'b0, txq16.pop_front()}; have = 1; end
            if (push_rx) rxq16.push_back(fd[31:0]);
        end
        for (int i = 0; i < nbits; i++) begin
            bclk = 1'b0;
            lrclk = (i == 0);
            adcdat = (i < nb) ? fd[nb-1-i] : 1'($urandom_range(0, 1));
            if (i == raise_at) en24 = 1'b1;
            repeat (4) @(negedge clk);
            bclk = 1'b1;
            if (i < nb) got[nb-1-i] = (bsz == 24) ? dac24 : dac16;
            if (i == nb - 1) lsb_cyc = cyc;
            repeat (4) @(negedge clk);
        end
        if (chk_tx) begin
            check("tx_have_load", {63'b0, have}, 64'd1);
            if (have) check("tx_dacdat", {16'b0, got}, {16'b0, exp});
        end
        $display("FRAME bsz=%0d bits=%0d adc=%h dac=%h", bsz, nbits, fd, got);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        en24 = 1'b1;
        en16 = 1'b0;
        bclk = 1'b0;
        lrclk = 1'b0;
        adcdat = 1'b0;
        lin24 = 24'h800001;
        rin24 = 24'h7FFFFF;
        lin16 = 16'h0100;
        rin16 = 16'hF000;

        // Reset held 4 cycles with a busy serial bus.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_dacdat", {63'b0, dac24}, 64'd0);
            bclk = ~bclk;
            lrclk = 1'b1;
            adcdat = 1'b1;
        end
        check("rst_left_out", {40'b0, lo24}, 64'd0);
        check("rst_right_out", {40'b0, ro24}, 64'd0);
        check("rst_out_valid", {63'b0, ov24}, 64'd0);
        check("rst_in_ready", {63'b0, ir24}, 64'd0);
        check("rst_frame_err", {63'b0, fe24}, 64'd0);
        bclk = 1'b0;
        lrclk = 1'b0;
        adcdat = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_dacdat", {63'b0, dac24}, 64'd0);

        // RX frame, then TX readback of 0x800001/0x7FFFFF in the next frame.
        send_frame(24, {24'hABCDEF, 24'h123456}, 64, -1, 1, 0);
        check("rxA_out_valid_count", 64'(ov24_cnt), 64'd1);
        check("rxA_frame_err_count", 64'(fe24_cnt), 64'd0);
        check("rxA_in_ready_count", 64'(ir24_cnt), 64'd1);
        send_frame(24, {24'h5A5A5A, 24'hC3C3C3}, 64, -1, 1, 1);
        check("rxB_out_valid_count", 64'(ov24_cnt), 64'd2);

        // Early frame pulse after 30 bits.
        send_frame(24, {24'hFFFFFF, 24'hFFFFFF}, 30, -1, 0, 0);
        send_frame(24, {24'h000001, 24'h800000}, 64, -1, 1, 0);
        check("early_frame_err_count", 64'(fe24_cnt), 64'd1);
        check("early_out_valid_count", 64'(ov24_cnt), 64'd3);

        // Enable raised 10 BCLKs into a frame.
        en24 = 1'b0;
        send_frame(24, {24'h135790, 24'h2468AC}, 64, 10, 0, 0);
        check("enmid_out_valid_count", 64'(ov24_cnt), 64'd3);
        send_frame(24, {24'hFEDCBA, 24'h987654}, 64, -1, 1, 0);
        check("enmid_next_out_valid", 64'(ov24_cnt), 64'd4);
        send_frame(24, {24'h0F0F0F, 24'hF0F0F0}, 64, -1, 1, 1);
        check("enmid_after_out_valid", 64'(ov24_cnt), 64'd5);
        check("rxq24_drained", 64'(rxq24.size()), 64'd0);

        // Streaming on the 16-bit instance.
        en24 = 1'b0;
        en16 = 1'b1;
        repeat (8) @(negedge clk);
        check("disabled_dacdat24", {63'b0, dac24}, 64'd0);
        for (int f = 0; f < 100; f++) begin
            logic [15:0] l16, r16;
            l16 = 16'(3 * f + 1);
            r16 = ~16'(f);
            send_frame(16, {16'b0, l16, r16}, 64, -1, 1, f > 0);
        end
        check("stream_out_valid_count", 64'(ov16_cnt), 64'd100);
        check("stream_in_ready_count", 64'(ir16_cnt), 64'd100);
        check("stream_frame_err_count", 64'(fe16_cnt), 64'd0);
        check("rxq16_drained", 64'(rxq16.size()), 64'd0);
        check("idle24_out_valid_count", 64'(ov24_cnt), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
